// File: rtl/jtag_chain_ctrl.sv
// jtag_chain_ctrl
// Shared capture/shift/update sequencer for the two JTAG user data chains
// (ER1/ER2) behind the hard JTAG primitive. A single DATA_W shift register is
// time-shared between the chains. A scan is committed to the selected chain's
// shadow register only when exactly DATA_W bits were shifted.
//
// Ports (all synchronous to JTCK, JRST async active-high):
//   JTDI, JSHIFT, JUPDATE     TAP serial data and Shift-DR / Update-DR levels
//   JCE1, JCE2                per-chain capture/shift enables
//   JRTI1, JRTI2              Run-Test/Idle levels per chain
//   CAP1, CAP2                per-chain capture values
//   JTD1, JTD2                per-chain serial outputs
//   UPD1, UPD2                committed shadow values
//   UPD1_STB, UPD2_STB        one-cycle commit strobes
//   RTI1_STB, RTI2_STB        one-cycle strobes on JRTIx rising edge
//   ERR                       sticky: [0] length error, [1] chain collision
//
// state | meaning
// IDLE  | waiting for a capture (JCEx=1, JSHIFT=0)
// SCAN  | chain selected; shifting, pausing, or waiting for update
module jtag_chain_ctrl #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 4
) (
    input  logic              JTCK,
    input  logic              JRST,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE1,
    input  logic              JCE2,
    input  logic              JRTI1,
    input  logic              JRTI2,
    input  logic [DATA_W-1:0] CAP1,
    input  logic [DATA_W-1:0] CAP2,
    output logic              JTD1,
    output logic              JTD2,
    output logic [DATA_W-1:0] UPD1,
    output logic [DATA_W-1:0] UPD2,
    output logic              UPD1_STB,
    output logic              UPD2_STB,
    output logic              RTI1_STB,
    output logic              RTI2_STB,
    output logic [1:0]        ERR
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(DATA_W + 1);
    localparam logic [1:0]       SEL_C1  = 2'd1;
    localparam logic [1:0]       SEL_C2  = 2'd2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_sel;
    logic [DATA_W-1:0]   r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_upd1;
    logic [DATA_W-1:0]   r_upd2;
    logic                r_upd1_stb;
    logic                r_upd2_stb;
    logic                r_upd_d;
    logic                r_rti1_d;
    logic                r_rti2_d;
    logic                r_rti1_stb;
    logic                r_rti2_stb;
    logic [1:0]          r_err;

    logic                w_upd_rise;
    logic                w_sel_ce;
    logic                w_oth_ce;
    logic                w_cap1;
    logic                w_cap2;
    logic                w_shift;
    logic                w_commit;
    logic                w_len_err;
    logic                w_coll;

    assign w_upd_rise = JUPDATE & ~r_upd_d;
    // In SCAN, r_sel is always C1 or C2, so anything not C1 is chain 2.
    assign w_sel_ce   = (r_sel == SEL_C1) ? JCE1 : JCE2;
    assign w_oth_ce   = (r_sel == SEL_C1) ? JCE2 : JCE1;

    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap1      = 1'b0;
        w_cap2      = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_len_err   = 1'b0;
        w_coll      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Enables seen with JSHIFT high here had no capture; ignore.
                if (!JSHIFT) begin
                    if (JCE1) begin
                        w_cap1      = 1'b1;
                        w_coll      = JCE2;
                        w_state_nxt = ST_SCAN;
                    end else if (JCE2) begin
                        w_cap2      = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                w_coll = w_oth_ce;
                if (w_upd_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_cnt == LP_FULL) begin
                        w_commit = 1'b1;
                    end else begin
                        w_len_err = 1'b1;
                    end
                end else if (w_sel_ce && JSHIFT) begin
                    w_shift = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            r_sel      <= '0;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_upd1     <= '0;
            r_upd2     <= '0;
            r_upd1_stb <= 1'b0;
            r_upd2_stb <= 1'b0;
            r_upd_d    <= 1'b0;
            r_rti1_d   <= 1'b0;
            r_rti2_d   <= 1'b0;
            r_rti1_stb <= 1'b0;
            r_rti2_stb <= 1'b0;
            r_err      <= '0;
        end else begin
            r_upd_d    <= JUPDATE;
            r_rti1_d   <= JRTI1;
            r_rti2_d   <= JRTI2;
            r_rti1_stb <= JRTI1 & ~r_rti1_d;
            r_rti2_stb <= JRTI2 & ~r_rti2_d;
            r_upd1_stb <= 1'b0;
            r_upd2_stb <= 1'b0;
            if (w_cap1) begin
                r_sr  <= CAP1;
                r_sel <= SEL_C1;
                r_cnt <= '0;
            end else if (w_cap2) begin
                r_sr  <= CAP2;
                r_sel <= SEL_C2;
                r_cnt <= '0;
            end
            if (w_shift) begin
                r_sr <= {JTDI, r_sr[DATA_W-1:1]};
                // Saturate one past full so over-long scans never wrap back
                // to an exact-length count.
                if (r_cnt != LP_SAT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_commit) begin
                if (r_sel == SEL_C1) begin
                    r_upd1     <= r_sr;
                    r_upd1_stb <= 1'b1;
                end else begin
                    r_upd2     <= r_sr;
                    r_upd2_stb <= 1'b1;
                end
            end
            if (w_len_err) begin
                r_err[0] <= 1'b1;
            end
            if (w_coll) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign JTD1     = (r_state == ST_SCAN) && (r_sel == SEL_C1) && r_sr[0];
    assign JTD2     = (r_state == ST_SCAN) && (r_sel == SEL_C2) && r_sr[0];
    assign UPD1     = r_upd1;
    assign UPD2     = r_upd2;
    assign UPD1_STB = r_upd1_stb;
    assign UPD2_STB = r_upd2_stb;
    assign RTI1_STB = r_rti1_stb;
    assign RTI2_STB = r_rti2_stb;
    assign ERR      = r_err;

endmodule

// File: tb/tb_jtag_chain_ctrl.sv
module tb_jtag_chain_ctrl;

    localparam int DW = 9;

    logic          JTCK = 1'b0;
    logic          JRST = 1'b1;
    logic          JTDI = 1'b0;
    logic          JSHIFT = 1'b0;
    logic          JUPDATE = 1'b0;
    logic          JCE1 = 1'b0;
    logic          JCE2 = 1'b0;
    logic          JRTI1 = 1'b0;
    logic          JRTI2 = 1'b0;
    logic [DW-1:0] CAP1 = '0;
    logic [DW-1:0] CAP2 = '0;
    logic          JTD1, JTD2;
    logic [DW-1:0] UPD1, UPD2;
    logic          UPD1_STB, UPD2_STB, RTI1_STB, RTI2_STB;
    logic [1:0]    ERR;

    jtag_chain_ctrl #(.DATA_W(DW), .CNT_W(4)) dut (
        .JTCK(JTCK), .JRST(JRST), .JTDI(JTDI), .JSHIFT(JSHIFT),
        .JUPDATE(JUPDATE), .JCE1(JCE1), .JCE2(JCE2), .JRTI1(JRTI1),
        .JRTI2(JRTI2), .CAP1(CAP1), .CAP2(CAP2), .JTD1(JTD1), .JTD2(JTD2),
        .UPD1(UPD1), .UPD2(UPD2), .UPD1_STB(UPD1_STB), .UPD2_STB(UPD2_STB),
        .RTI1_STB(RTI1_STB), .RTI2_STB(RTI2_STB), .ERR(ERR)
    );

    always #5 JTCK = ~JTCK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a scan is "capture value bits, then the bits shifted in", read
    // out in order; a commit is the shifted-in stream taken LSB first.
    bit            m_scan;
    int            m_chain;
    logic [DW-1:0] m_cap;
    bit            m_bits[$];
    logic [DW-1:0] m_upd1, m_upd2;
    bit            m_ustb1, m_ustb2, m_rstb1, m_rstb2;
    bit            m_rti1_prev, m_rti2_prev, m_upd_prev;
    logic [1:0]    m_err;
    bit            m_checking = 0;

    always @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            m_scan = 0; m_chain = 0; m_cap = '0; m_bits.delete();
            m_upd1 = '0; m_upd2 = '0; m_ustb1 = 0; m_ustb2 = 0;
            m_rstb1 = 0; m_rstb2 = 0; m_rti1_prev = 0; m_rti2_prev = 0;
            m_upd_prev = 0; m_err = '0;
        end else begin
            bit rise;
            bit sel_ce, oth_ce;
            rise = JUPDATE && !m_upd_prev;
            m_upd_prev = JUPDATE;
            m_rstb1 = JRTI1 && !m_rti1_prev; m_rti1_prev = JRTI1;
            m_rstb2 = JRTI2 && !m_rti2_prev; m_rti2_prev = JRTI2;
            m_ustb1 = 0; m_ustb2 = 0;
            if (!m_scan) begin
                if (!JSHIFT && (JCE1 || JCE2)) begin
                    m_scan  = 1;
                    m_chain = JCE1 ? 1 : 2;
                    m_cap   = JCE1 ? CAP1 : CAP2;
                    m_bits.delete();
                    if (JCE1 && JCE2) m_err[1] = 1'b1;
                end
            end else begin
                sel_ce = (m_chain == 1) ? JCE1 : JCE2;
                oth_ce = (m_chain == 1) ? JCE2 : JCE1;
                if (oth_ce) m_err[1] = 1'b1;
                if (rise) begin
                    m_scan = 0;
                    if (m_bits.size() == DW) begin
                        int v;
                        v = 0;
                        for (int i = 0; i < DW; i++) v = v + (int'(m_bits[i]) << i);
                        if (m_chain == 1) begin m_upd1 = v[DW-1:0]; m_ustb1 = 1; end
                        else begin m_upd2 = v[DW-1:0]; m_ustb2 = 1; end
                    end else begin
                        m_err[0] = 1'b1;
                    end
                end else if (sel_ce && JSHIFT) begin
                    m_bits.push_back(JTDI);
                end
            end
        end
    end

    function automatic bit m_jtd(input int ch);
        int k;
        if (!m_scan || m_chain != ch) return 0;
        k = m_bits.size();
        if (k < DW) return m_cap[k];
        return m_bits[k-DW];
    endfunction

    always @(negedge JTCK) begin
        if (m_checking && !JRST) begin
            chk("jtd1", JTD1, m_jtd(1));
            chk("jtd2", JTD2, m_jtd(2));
            chk("upd1", UPD1, m_upd1);
            chk("upd2", UPD2, m_upd2);
            chk("upd1_stb", UPD1_STB, m_ustb1);
            chk("upd2_stb", UPD2_STB, m_ustb2);
            chk("rti1_stb", RTI1_STB, m_rstb1);
            chk("rti2_stb", RTI2_STB, m_rstb2);
            chk("err", ERR, m_err);
        end
    end

    task automatic step(input logic ce1, input logic ce2, input logic sh,
                        input logic up, input logic di);
        JCE1 = ce1; JCE2 = ce2; JSHIFT = sh; JUPDATE = up; JTDI = di;
        @(posedge JTCK);
        #1;
    endtask

    // Full scan on chain ch: capture, nbits shifts (optional pause and
    // other-chain enable pulse), exit, upd_len update cycles, idle.
    task automatic scan(input int ch, input logic [DW-1:0] val, input int nbits,
                        input int pause_at, input int pause_len, input int upd_len,
                        input bit both, input int oth_at, input bit chk_jtd,
                        input logic [DW-1:0] exp_jtd, input bit exp_commit);
        logic c1, c2, b;
        c1 = (ch == 1) || both;
        c2 = (ch == 2) || both;
        step(c1, c2, 1'b0, 1'b0, 1'b0);
        if (both) chk("jtd2_coll_lit", JTD2, 0);
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at) repeat (pause_len) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (chk_jtd && i < DW) chk("jtd_seq_lit", (ch == 1) ? JTD1 : JTD2, exp_jtd[i]);
            b = (i < DW) ? val[i] : 1'(i % 2);
            step((ch == 1) || (i == oth_at), (ch == 2) || (i == oth_at), 1'b1, 1'b0, b);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int u = 0; u < upd_len; u++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("upd_stb_lit", (ch == 1) ? UPD1_STB : UPD2_STB, (u == 0) ? exp_commit : 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("upd_stb_after_lit", (ch == 1) ? UPD1_STB : UPD2_STB, 0);
    endtask

    initial begin
        CAP1 = 9'h155;
        CAP2 = 9'h003;
        repeat (3) @(posedge JTCK);
        #1;
        chk("rst_upd1", UPD1, 0);
        chk("rst_err", ERR, 0);
        chk("rst_jtd1", JTD1, 0);
        chk("rst_stb", {UPD1_STB, UPD2_STB, RTI1_STB, RTI2_STB}, 0);
        JRST = 1'b0;
        m_checking = 1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-shift after 4 bits: no commit.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        JRST = 1'b1;
        #1;
        chk("midrst_jtd1", JTD1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        JRST = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("midrst_stb", UPD1_STB, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_upd1", UPD1, 0);

        // Chain 1 exact scan.
        scan(1, 9'h0A3, 9, -1, 0, 1, 0, -1, 1, 9'h155, 1);
        chk("c1_upd1_lit", UPD1, 9'h0A3);
        chk("c1_err_lit", ERR, 2'b00);

        // Chain 2 short scan, then a good one.
        scan(2, 9'h0FF, 8, -1, 0, 1, 0, -1, 1, 9'h003, 0);
        chk("c2_short_upd2_lit", UPD2, 0);
        chk("c2_short_err_lit", ERR, 2'b01);
        scan(2, 9'h1C5, 9, -1, 0, 1, 0, -1, 0, '0, 1);
        chk("c2_good_upd2_lit", UPD2, 9'h1C5);

        // Collision at capture plus a JCE2 pulse mid-scan.
        scan(1, 9'h0F0, 9, -1, 0, 1, 1, 3, 0, '0, 1);
        chk("coll_upd1_lit", UPD1, 9'h0F0);
        chk("coll_err_lit", ERR, 2'b11);

        // Pause mid-scan, long update, over-long scan.
        scan(1, 9'h05A, 9, 4, 5, 1, 0, -1, 0, '0, 1);
        chk("pause_upd1_lit", UPD1, 9'h05A);
        scan(1, 9'h111, 9, -1, 0, 3, 0, -1, 0, '0, 1);
        chk("longupd_upd1_lit", UPD1, 9'h111);
        scan(1, 9'h1FF, 12, -1, 0, 1, 0, -1, 0, '0, 0);
        chk("long_upd1_lit", UPD1, 9'h111);

        // RTI edge strobe.
        JRTI1 = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rti1_rise_lit", RTI1_STB, 1);
        chk("rti2_quiet_lit", RTI2_STB, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rti1_once_lit", RTI1_STB, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        JRTI1 = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rti1_fall_lit", RTI1_STB, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
